// File: rtl/tmr_clock_select.sv
// tmr_clock_select: count-source front end for one 8-bit timer channel.
// Selects between the internal prescaler taps, the partner-channel cascade
// pulse and the external TMCI pin, and turns external TMRI rising edges
// into a clear request. Both outputs are registered one-cycle pulses.
//
// Optional build macro: TMR_NOISE_FILTER_EN adds a digital glitch filter on
// the synchronized TMCI and TMRI levels (FILTER_LEN stable cycles).
module tmr_clock_select #(
  parameter int BIT_WIDTH   = 8,
  parameter int DIV_A       = 8,
  parameter int DIV_B       = 64,
  parameter int DIV_C       = 8192,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [BIT_WIDTH-1:0]       cks_reg,
  input  logic                       tmrie,
  input  logic                       cascade_in,
  input  logic                       tmci,
  input  logic                       tmri,
  output logic                       count_en,
  output logic                       clear_req,
  output logic [$clog2(DIV_C)-1:0]   presc_q
);

  localparam int PW = $clog2(DIV_C);
  localparam logic [PW-1:0] MASK_A = PW'(DIV_A - 1);
  localparam logic [PW-1:0] MASK_B = PW'(DIV_B - 1);
  localparam logic [PW-1:0] MASK_C = PW'(DIV_C - 1);

  logic [PW-1:0]          presc;
  logic [SYNC_STAGES-1:0] tmci_sync;
  logic [SYNC_STAGES-1:0] tmri_sync;
  logic                   tmci_lvl;
  logic                   tmri_lvl;
  logic                   tmci_hist;
  logic                   tmri_hist;
  logic                   tick_a;
  logic                   tick_b;
  logic                   tick_c;
  logic                   tmci_rise;
  logic                   tmci_fall;
  logic                   tmri_rise;
  logic                   count_nxt;
  logic                   unused_cks_hi;

  // Only CKS [2:0] matters; the remaining register bits belong to other fields.
  assign unused_cks_hi = ^cks_reg[BIT_WIDTH-1:3];

  // Free-running prescaler; never disturbed by CKS changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else        presc <= presc + 1'b1;
  end

  assign presc_q = presc;
  assign tick_a  = (presc & MASK_A) == MASK_A;
  assign tick_b  = (presc & MASK_B) == MASK_B;
  assign tick_c  = (presc & MASK_C) == MASK_C;

  // Metastability synchronizers for the two asynchronous pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmci_sync <= '0;
      tmri_sync <= '0;
    end else begin
      tmci_sync <= {tmci_sync[SYNC_STAGES-2:0], tmci};
      tmri_sync <= {tmri_sync[SYNC_STAGES-2:0], tmri};
    end
  end

`ifdef TMR_NOISE_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

  logic [FW-1:0] tmci_fcnt;
  logic [FW-1:0] tmri_fcnt;
  logic          tmci_filt;
  logic          tmri_filt;

  // TMCI filter: adopt a new level only after FILTER_LEN consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmci_filt <= 1'b0;
      tmci_fcnt <= '0;
    end else if (tmci_sync[SYNC_STAGES-1] == tmci_filt) begin
      tmci_fcnt <= '0;
    end else if (tmci_fcnt == FILT_LAST) begin
      tmci_filt <= tmci_sync[SYNC_STAGES-1];
      tmci_fcnt <= '0;
    end else begin
      tmci_fcnt <= tmci_fcnt + 1'b1;
    end
  end

  // TMRI filter: same qualification as TMCI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmri_filt <= 1'b0;
      tmri_fcnt <= '0;
    end else if (tmri_sync[SYNC_STAGES-1] == tmri_filt) begin
      tmri_fcnt <= '0;
    end else if (tmri_fcnt == FILT_LAST) begin
      tmri_filt <= tmri_sync[SYNC_STAGES-1];
      tmri_fcnt <= '0;
    end else begin
      tmri_fcnt <= tmri_fcnt + 1'b1;
    end
  end

  assign tmci_lvl = tmci_filt;
  assign tmri_lvl = tmri_filt;
`else
  assign tmci_lvl = tmci_sync[SYNC_STAGES-1];
  assign tmri_lvl = tmri_sync[SYNC_STAGES-1];
`endif

  // History flops; resetting to 0 means a pin high at release still needs
  // to propagate through the synchronizer before it registers as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmci_hist <= 1'b0;
      tmri_hist <= 1'b0;
    end else begin
      tmci_hist <= tmci_lvl;
      tmri_hist <= tmri_lvl;
    end
  end

  assign tmci_rise = tmci_lvl & ~tmci_hist;
  assign tmci_fall = ~tmci_lvl & tmci_hist;
  assign tmri_rise = tmri_lvl & ~tmri_hist;

  // Count-source select; exactly one source is routed, so at most one pulse per cycle.
  always_comb begin
    count_nxt = 1'b0;
    case (cks_reg[2:0])
      3'b000:  count_nxt = 1'b0;
      3'b001:  count_nxt = tick_a;
      3'b010:  count_nxt = tick_b;
      3'b011:  count_nxt = tick_c;
      3'b100:  count_nxt = cascade_in;
      3'b101:  count_nxt = tmci_rise;
      3'b110:  count_nxt = tmci_fall;
      3'b111:  count_nxt = tmci_rise | tmci_fall;
      default: count_nxt = 1'b0;
    endcase
  end

  // Output pulses are registered; clear priority is resolved downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_en  <= 1'b0;
      clear_req <= 1'b0;
    end else begin
      count_en  <= count_nxt;
      clear_req <= tmri_rise & tmrie;
    end
  end

endmodule

// File: tb/tb_tmr_clock_select.sv
// Scoreboard bench for tmr_clock_select: stimulus pushes the cycle numbers
// at which count_en / clear_req pulses are due; a negedge monitor pops them.
module tb_tmr_clock_select;

`ifdef TMR_NOISE_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cks_reg;
  logic        tmrie;
  logic        cascade_in;
  logic        tmci;
  logic        tmri;
  logic        count_en;
  logic        clear_req;
  logic [12:0] presc_q;

  int cyc = 0;
  int base = 0;
  int compared = 0;
  int mismatched = 0;
  int exp_cnt_q[$];
  int exp_clr_q[$];

  tmr_clock_select dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cks_reg    (cks_reg),
    .tmrie      (tmrie),
    .cascade_in (cascade_in),
    .tmci       (tmci),
    .tmri       (tmri),
    .count_en   (count_en),
    .clear_req  (clear_req),
    .presc_q    (presc_q)
  );

  always #5 clk = ~clk;

  // Cycle index: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every output pulse must match the oldest expected cycle.
  always @(negedge clk) begin
    if (count_en === 1'b1) begin
      if (exp_cnt_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL count_en_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        check("count_en_cycle", cyc, exp_cnt_q.pop_front());
      end
    end
    if (clear_req === 1'b1) begin
      if (exp_clr_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL clear_req_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        check("clear_req_cycle", cyc, exp_clr_q.pop_front());
      end
    end
  end

  task automatic drained(input string name);
    check({name, "_cnt_left"}, exp_cnt_q.size(), 0);
    check({name, "_clr_left"}, exp_clr_q.size(), 0);
    exp_cnt_q.delete();
    exp_clr_q.delete();
  endtask

  // Expected tick_A pulses in cycles [from, to]: due when (c-base) % 8 == 0.
  task automatic push_tick_a(input int from, input int to);
    for (int c = from; c <= to; c++)
      if (((c - base) % 8) == 0) exp_cnt_q.push_back(c);
  endtask

  task automatic ext_pulse(input logic [2:0] mode, input int hi, input bit er, input bit ef);
    int t;
    cks_reg = {5'b0, mode};
    tick(5);
    t = cyc;
    tmci = 1'b1;
    if (er) exp_cnt_q.push_back(t + LAT);
    tick(hi);
    tmci = 1'b0;
    if (ef) exp_cnt_q.push_back(t + hi + LAT);
    tick(LAT + 8);
    drained($sformatf("ext_mode%0d_hi%0d", mode, hi));
  endtask

  initial begin
    int t;
    rst_n = 1'b0; cks_reg = 8'h00; tmrie = 1'b0;
    cascade_in = 1'b0; tmci = 1'b0; tmri = 1'b0;
    tick(3);
    check("reset_count_en", int'(count_en), 0);
    check("reset_clear_req", int'(clear_req), 0);
    check("reset_presc", int'(presc_q), 0);

    // tick_A: first pulse 8 cycles after release, 12 pulses in 100 cycles.
    cks_reg = 8'h01;
    rst_n = 1'b1;
    base = cyc;
    for (int i = 1; i <= 12; i++) exp_cnt_q.push_back(base + 8 * i);
    tick(100);
    drained("tick_a");
    check("presc_after_100", int'(presc_q), 100);

    // tick_C: one pulse per 8192 cycles, then stop mid-period.
    cks_reg = 8'h03;
    exp_cnt_q.push_back(base + 8192);
    tick(8092 + 4000);
    drained("tick_c");
    cks_reg = 8'h00;
    tick(4202);
    drained("stopped");
    check("presc_keeps_counting", int'(presc_q), (cyc - base) & 8191);

    // External clock modes.
    ext_pulse(3'b101, 10, 1'b1, 1'b0);
    ext_pulse(3'b111, 10, 1'b1, 1'b1);
    ext_pulse(3'b110, 10, 1'b0, 1'b1);
`ifdef TMR_NOISE_FILTER_EN
    ext_pulse(3'b101, 2, 1'b0, 1'b0);
    ext_pulse(3'b101, 5, 1'b1, 1'b0);
`else
    ext_pulse(3'b111, 1, 1'b1, 1'b1);
`endif

    // Cascade source: pulses at t+5, t+6 give count_en at t+6, t+7.
    cks_reg = 8'h04;
    tick(1);
    t = cyc;
    tick(5);
    cascade_in = 1'b1; exp_cnt_q.push_back(t + 6);
    tick(1);
    exp_cnt_q.push_back(t + 7);
    tick(1);
    cascade_in = 1'b0;
    tick(5);
    drained("cascade");

    // Same cascade stimulus under tick_A with junk in upper register bits.
    cks_reg = 8'hF9;
    t = cyc;
    push_tick_a(t + 1, t + 20);
    tick(5);
    cascade_in = 1'b1;
    tick(2);
    cascade_in = 1'b0;
    tick(13);
    cks_reg = 8'h00;
    tick(10);
    drained("cascade_ignored");

    // External reset pin.
    tmrie = 1'b1;
    t = cyc;
    tmri = 1'b1; exp_clr_q.push_back(t + LAT);
    tick(10);
    tmri = 1'b0;
    tick(LAT + 5);
    drained("tmri_enabled");
    tmrie = 1'b0;
    tmri = 1'b1;
    tick(10);
    tmri = 1'b0;
    tick(LAT + 5);
    drained("tmri_disabled");

    // Reset while a TMCI edge is still in the synchronizer.
    cks_reg = 8'h05;
    tick(2);
    tmci = 1'b1;
    tick(1);
    rst_n = 1'b0;
    #1;
    check("midreset_count_en", int'(count_en), 0);
    check("midreset_presc", int'(presc_q), 0);
    tmci = 1'b0;
    tick(3);
    rst_n = 1'b1;
    base = cyc;
    tick(15);
    drained("after_midreset");
    check("presc_after_rerelease", int'(presc_q), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
